dx_hazard_latch: RTL and testbench

- Decode-to-execute (D/X) pipeline register of the 5-stage core, with load-use hazard detection and stall/flush sequencing.
- Produces the DX instruction word that the X-stage bypass control decodes. Bubbles are inserted only where forwarding cannot cover the hazard.
- Drives the enable of the PC and F/D latch, and keeps a saturating load-use stall counter for performance debug.

---
 rtl/dx_hazard_latch_if.sv | 51 +++++
 rtl/dx_hazard_latch.sv | 148 ++++++++++++++
 tb/tb_dx_hazard_latch.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dx_hazard_latch_if.sv
// ----------------------------------------------------------------------------
// dx_hazard_latch_if
//   Groups the F/D-side inputs and D/X-side outputs of the decode-to-execute
//   pipeline register into one bundle.
//
//   F/D side (into the latch):
//     fd_ir, fd_pc       instruction in F/D and its PC+1
//     rf_a, rf_b         register-file read data for fd_ir
//     flush              taken branch/jump resolved in X, squash D/X
//     ext_stall          multdiv busy, freeze D/X and F/D
//   D/X side (out of the latch):
//     dx_ir, dx_pc       registered instruction and PC
//     dx_a, dx_b         registered operands
//     dx_valid           1 = real instruction, 0 = bubble
//     fd_enable          combinational write enable for PC and F/D latch
//     load_use           combinational load-use hazard flag
//     stall_count        saturating count of load-use bubbles
//
//   master: the environment driving F/D (core front end / testbench)
//   slave:  the D/X latch itself
// ----------------------------------------------------------------------------
interface dx_hazard_latch_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] fd_ir;
  logic [WIDTH-1:0] fd_pc;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic             flush;
  logic             ext_stall;

  logic [WIDTH-1:0] dx_ir;
  logic [WIDTH-1:0] dx_pc;
  logic [WIDTH-1:0] dx_a;
  logic [WIDTH-1:0] dx_b;
  logic             dx_valid;
  logic             fd_enable;
  logic             load_use;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output fd_ir, fd_pc, rf_a, rf_b, flush, ext_stall,
    input  dx_ir, dx_pc, dx_a, dx_b, dx_valid, fd_enable, load_use, stall_count
  );

  modport slave (
    input  fd_ir, fd_pc, rf_a, rf_b, flush, ext_stall,
    output dx_ir, dx_pc, dx_a, dx_b, dx_valid, fd_enable, load_use, stall_count
  );
endinterface

// File: rtl/dx_hazard_latch.sv
// ----------------------------------------------------------------------------
// dx_hazard_latch
//   Decode-to-execute pipeline register of the 5-stage core. Detects load-use
//   hazards that forwarding cannot cover and inserts exactly one bubble for
//   each, sequences flush and external stall, and keeps a saturating count of
//   load-use bubbles for performance debug.
//
//   Ports:
//     clock     core clock, rising edge
//     reset_n   asynchronous active-low reset
//     bus       dx_hazard_latch_if.slave (F/D inputs, D/X outputs)
//
//   Instruction fields (both F/D and D/X words):
//     op = [31:27], rd = [26:22], rs = [21:17], rt = [16:12]
// ----------------------------------------------------------------------------
module dx_hazard_latch #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = '0,
  parameter int               CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  dx_hazard_latch_if.slave    bus
);

  localparam logic [4:0] opAlu   = 5'd0;
  localparam logic [4:0] opBne   = 5'd2;
  localparam logic [4:0] opJr    = 5'd4;
  localparam logic [4:0] opAddi  = 5'd5;
  localparam logic [4:0] opBlt   = 5'd6;
  localparam logic [4:0] opSw    = 5'd7;
  localparam logic [4:0] opLw    = 5'd8;

  localparam logic [CNT_W-1:0] cntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Priority-resolved action for this cycle.
  typedef enum logic [1:0] {
    actLoad,
    actBubble,
    actHold,
    actFlush
  } actionE;

  logic [WIDTH-1:0] dxIr;
  logic [WIDTH-1:0] dxPc;
  logic [WIDTH-1:0] dxA;
  logic [WIDTH-1:0] dxB;
  logic             dxValid;
  logic [CNT_W-1:0] stallCount;

  logic [4:0] fdOp;
  logic [4:0] fdRd;
  logic [4:0] fdRs;
  logic [4:0] fdRt;
  logic [4:0] dxOp;
  logic [4:0] dxRd;
  logic       srcMatch;
  logic       loadUse;
  actionE     action;

  assign fdOp = bus.fd_ir[31:27];
  assign fdRd = bus.fd_ir[26:22];
  assign fdRs = bus.fd_ir[21:17];
  assign fdRt = bus.fd_ir[16:12];
  assign dxOp = dxIr[31:27];
  assign dxRd = dxIr[26:22];

  // Which source registers of the F/D instruction must be ready at the start
  // of X. Store data (rd of sw) is deliberately absent: it reaches memory
  // through the M-stage bypass, so a preceding lw never stalls it.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    srcMatch = 1'b0;
    case (fdOp)
      opAlu:        srcMatch = (fdRs == dxRd) || (fdRt == dxRd);
      opAddi, opLw: srcMatch = (fdRs == dxRd);
      opSw:         srcMatch = (fdRs == dxRd);
      opBne, opBlt: srcMatch = (fdRd == dxRd) || (fdRs == dxRd);
      opJr:         srcMatch = (fdRd == dxRd);
      default:      srcMatch = 1'b0;
    endcase
  end

  // A bubble in D/X can never create a hazard; the dxValid term also keeps
  // the flag defined while fd_ir is unknown behind a bubble.
  assign loadUse = dxValid && (dxOp == opLw) && srcMatch;

  always_comb begin
    action = actLoad;
    if (bus.flush)          action = actFlush;
    else if (bus.ext_stall) action = actHold;
    else if (loadUse)       action = actBubble;
  end

  // F/D advances whenever D/X accepts a new entry or the flush redirects fetch.
  assign bus.fd_enable = (action == actFlush) || (action == actLoad);
  assign bus.load_use  = loadUse;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dxIr       <= NOP;
      dxPc       <= '0;
      dxA        <= '0;
      dxB        <= '0;
      dxValid    <= 1'b0;
      stallCount <= '0;
    end else begin
      case (action)
        actFlush: begin
          dxIr    <= NOP;
          dxPc    <= '0;
          dxA     <= '0;
          dxB     <= '0;
          dxValid <= 1'b0;
        end
        actHold: begin
          // D/X keeps its contents; the F/D latch is frozen via fd_enable.
        end
        actBubble: begin
          dxIr    <= NOP;
          dxPc    <= '0;
          dxA     <= '0;
          dxB     <= '0;
          dxValid <= 1'b0;
          if (stallCount != '1) stallCount <= stallCount + cntOne;
        end
        default: begin
          dxIr    <= bus.fd_ir;
          dxPc    <= bus.fd_pc;
          dxA     <= bus.rf_a;
          dxB     <= bus.rf_b;
          dxValid <= 1'b1;
        end
      endcase
    end
  end

  assign bus.dx_ir       = dxIr;
  assign bus.dx_pc       = dxPc;
  assign bus.dx_a        = dxA;
  assign bus.dx_b        = dxB;
  assign bus.dx_valid    = dxValid;
  assign bus.stall_count = stallCount;

endmodule

// File: tb/tb_dx_hazard_latch.sv
// ----------------------------------------------------------------------------
// tb_dx_hazard_latch
//   Directed bench for dx_hazard_latch. Two instances share one stimulus
//   stream: the default 16-bit counter and a CNT_W=2 copy for saturation.
//   Expected D/X contents are queued when a step is driven and popped after
//   the clock edge that produces them.
// ----------------------------------------------------------------------------
module tb_dx_hazard_latch;

  logic clock;
  logic reset_n;

  int checks = 0;
  int errors = 0;

  dx_hazard_latch_if #(.WIDTH(32), .CNT_W(16)) ifMain ();
  dx_hazard_latch_if #(.WIDTH(32), .CNT_W(2))  ifSmall ();

  assign ifSmall.fd_ir     = ifMain.fd_ir;
  assign ifSmall.fd_pc     = ifMain.fd_pc;
  assign ifSmall.rf_a      = ifMain.rf_a;
  assign ifSmall.rf_b      = ifMain.rf_b;
  assign ifSmall.flush     = ifMain.flush;
  assign ifSmall.ext_stall = ifMain.ext_stall;

  dx_hazard_latch #(.WIDTH(32), .NOP(32'h0), .CNT_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifMain)
  );

  dx_hazard_latch #(.WIDTH(32), .NOP(32'h0), .CNT_W(2)) dutSmall (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifSmall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid;
    logic [15:0] cnt;
    logic [1:0]  cntSmall;
  } expT;

  expT sb[$];

  // Expected D/X state after the most recently driven step.
  logic [31:0] mIr, mPc, mA, mB;
  logic        mValid;
  logic [15:0] mCnt;
  logic [1:0]  mCntSmall;

  localparam logic [31:0] LW  = 32'h40C20000; // lw  r3,0(r1)
  localparam logic [31:0] ADD = 32'h01464000; // add r5,r3,r4
  localparam logic [31:0] SW  = 32'h38CC0000; // sw  r3,0(r6)

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction

  function automatic void modelReset();
    mIr = 32'h0; mPc = 32'h0; mA = 32'h0; mB = 32'h0;
    mValid = 1'b0; mCnt = 16'h0; mCntSmall = 2'h0;
  endfunction

  // One clock of stimulus. expLu is the directed hazard verdict for the
  // driven F/D word against the current D/X word.
  task automatic step(input logic [31:0] ir, input logic [31:0] pc,
                      input logic fl, input logic st, input logic expLu,
                      input string tag);
    expT e;
    logic expFdEn;
    @(negedge clock);
    ifMain.fd_ir     = ir;
    ifMain.fd_pc     = pc;
    ifMain.rf_a      = 32'hA000_0000 ^ pc;
    ifMain.rf_b      = 32'hB000_0000 ^ (pc << 4);
    ifMain.flush     = fl;
    ifMain.ext_stall = st;
    #1;
    expFdEn = fl || (!st && !expLu);
    check({tag, ".load_use"},  {31'h0, ifMain.load_use},  {31'h0, expLu});
    check({tag, ".fd_enable"}, {31'h0, ifMain.fd_enable}, {31'h0, expFdEn});

    if (fl) begin
      mIr = 32'h0; mPc = 32'h0; mA = 32'h0; mB = 32'h0; mValid = 1'b0;
    end else if (st) begin
      // hold
    end else if (expLu) begin
      mIr = 32'h0; mPc = 32'h0; mA = 32'h0; mB = 32'h0; mValid = 1'b0;
      if (mCnt != 16'hFFFF) mCnt = mCnt + 16'h1;
      if (mCntSmall != 2'h3) mCntSmall = mCntSmall + 2'h1;
    end else begin
      mIr = ir; mPc = pc; mA = 32'hA000_0000 ^ pc; mB = 32'hB000_0000 ^ (pc << 4);
      mValid = 1'b1;
    end
    e = '{ir: mIr, pc: mPc, a: mA, b: mB, valid: mValid, cnt: mCnt, cntSmall: mCntSmall};
    sb.push_back(e);

    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({tag, ".dx_ir"},    ifMain.dx_ir, e.ir);
    check({tag, ".dx_pc"},    ifMain.dx_pc, e.pc);
    check({tag, ".dx_a"},     ifMain.dx_a,  e.a);
    check({tag, ".dx_b"},     ifMain.dx_b,  e.b);
    check({tag, ".dx_valid"}, {31'h0, ifMain.dx_valid}, {31'h0, e.valid});
    check({tag, ".stall_count"},       {16'h0, ifMain.stall_count},  {16'h0, e.cnt});
    check({tag, ".stall_count_small"}, {30'h0, ifSmall.stall_count}, {30'h0, e.cntSmall});
  endtask

  typedef struct {
    logic [31:0] ir;
    logic        lu;
    string       name;
  } depCaseT;

  initial begin
    depCaseT cases[13];

    cases[0]  = '{mk(5'd5, 5'd7, 5'd3, 5'd0), 1'b1, "addi_rs"};
    cases[1]  = '{mk(5'd5, 5'd3, 5'd1, 5'd3), 1'b0, "addi_rt"};
    cases[2]  = '{mk(5'd8, 5'd9, 5'd3, 5'd0), 1'b1, "lw_rs"};
    cases[3]  = '{mk(5'd0, 5'd9, 5'd1, 5'd3), 1'b1, "alu_rt"};
    cases[4]  = '{mk(5'd2, 5'd3, 5'd1, 5'd1), 1'b1, "bne_rd"};
    cases[5]  = '{mk(5'd6, 5'd1, 5'd3, 5'd2), 1'b1, "blt_rs"};
    cases[6]  = '{mk(5'd6, 5'd1, 5'd2, 5'd3), 1'b0, "blt_rt"};
    cases[7]  = '{mk(5'd4, 5'd3, 5'd0, 5'd0), 1'b1, "jr_rd"};
    cases[8]  = '{mk(5'd4, 5'd1, 5'd3, 5'd3), 1'b0, "jr_rs"};
    cases[9]  = '{mk(5'd3, 5'd3, 5'd3, 5'd3), 1'b0, "op3_none"};
    cases[10] = '{mk(5'd7, 5'd3, 5'd1, 5'd0), 1'b0, "sw_data"};
    cases[11] = '{mk(5'd7, 5'd1, 5'd3, 5'd0), 1'b1, "sw_base"};
    cases[12] = '{mk(5'd0, 5'd1, 5'd2, 5'd4), 1'b0, "alu_none"};

    reset_n          = 1'b0;
    ifMain.fd_ir     = 32'h0;
    ifMain.fd_pc     = 32'h0;
    ifMain.rf_a      = 32'h0;
    ifMain.rf_b      = 32'h0;
    ifMain.flush     = 1'b0;
    ifMain.ext_stall = 1'b0;
    modelReset();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset.dx_ir",       ifMain.dx_ir, 32'h0);
    check("reset.dx_valid",    {31'h0, ifMain.dx_valid}, 32'h0);
    check("reset.stall_count", {16'h0, ifMain.stall_count}, 32'h0);
    check("reset.fd_enable",   {31'h0, ifMain.fd_enable}, 32'h1);
    @(negedge clock);
    reset_n = 1'b1;

    // Load-use: one bubble, then the held add advances
    step(LW,  32'd1, 1'b0, 1'b0, 1'b0, "lu.lw");
    step(ADD, 32'd2, 1'b0, 1'b0, 1'b1, "lu.bubble");
    step(ADD, 32'd2, 1'b0, 1'b0, 1'b0, "lu.advance");

    // lw followed by sw of the loaded data: no stall
    step(LW,  32'd3, 1'b0, 1'b0, 1'b0, "sw.lw");
    step(SW,  32'd4, 1'b0, 1'b0, 1'b0, "sw.data");

    // Flush wins over a simultaneous load-use
    step(LW,  32'd5, 1'b0, 1'b0, 1'b0, "flush.lw");
    step(ADD, 32'd6, 1'b1, 1'b0, 1'b1, "flush.hazard");

    // ext_stall holds D/X for 3 cycles while F/D inputs change
    step(ADD, 32'd7, 1'b0, 1'b0, 1'b0, "stall.add");
    for (int i = 0; i < 3; i++)
      step(LW ^ (32'h1 << i), 32'd20 + i, 1'b0, 1'b1, 1'b0, "stall.hold");
    step(LW,  32'd11, 1'b0, 1'b0, 1'b0, "stall.release");

    // ext_stall over a live load-use: hold, then bubble once released
    step(ADD, 32'd12, 1'b0, 1'b1, 1'b1, "stall_lu.hold");
    step(ADD, 32'd12, 1'b0, 1'b0, 1'b1, "stall_lu.bubble");
    step(ADD, 32'd12, 1'b0, 1'b0, 1'b0, "stall_lu.advance");

    // Source-match per F/D opcode against lw r3
    for (int i = 0; i < 13; i++) begin
      step(LW, 32'd100 + 2 * i, 1'b0, 1'b0, 1'b0, "op.lw");
      step(cases[i].ir, 32'd101 + 2 * i, 1'b0, 1'b0, cases[i].lu, cases[i].name);
    end

    // r0 destination is not special-cased
    step(mk(5'd8, 5'd0, 5'd1, 5'd0), 32'd200, 1'b0, 1'b0, 1'b0, "r0.lw");
    step(mk(5'd0, 5'd2, 5'd0, 5'd1), 32'd201, 1'b0, 1'b0, 1'b1, "r0.add");

    // Asynchronous reset in the middle of a load-use stall
    step(LW, 32'd300, 1'b0, 1'b0, 1'b0, "rst.lw");
    @(negedge clock);
    ifMain.fd_ir = ADD;
    ifMain.fd_pc = 32'd301;
    #1;
    check("rst.pre.load_use", {31'h0, ifMain.load_use}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst.async.dx_ir",       ifMain.dx_ir, 32'h0);
    check("rst.async.dx_valid",    {31'h0, ifMain.dx_valid}, 32'h0);
    check("rst.async.stall_count", {16'h0, ifMain.stall_count}, 32'h0);
    check("rst.async.fd_enable",   {31'h0, ifMain.fd_enable}, 32'h1);
    @(posedge clock);
    #1;
    check("rst.edge.stall_count",  {16'h0, ifMain.stall_count}, 32'h0);
    check("rst.edge.dx_valid",     {31'h0, ifMain.dx_valid}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    modelReset();
    step(ADD, 32'd301, 1'b0, 1'b0, 1'b0, "rst.resume");

    check("scoreboard.empty", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
